// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the ultrasonic parking sensor.
`timescale 1ns/1ps
package parking_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    EVAL      = 3'd4
  } state_e;

  localparam int unsigned CLK_FREQ_HZ = 32'd20_000_000;

  // Converts a duration in microseconds into clock ticks at CLK_FREQ_HZ.
  function automatic int unsigned us_to_cycles(input int unsigned us);
    return us * (CLK_FREQ_HZ / 32'd1_000_000);
  endfunction

  localparam int unsigned TRIG_CYCLES_DEF     = us_to_cycles(32'd10);     // 200
  localparam int unsigned PERIOD_CYCLES_DEF   = us_to_cycles(32'd60_000); // 1_200_000
  localparam int unsigned ECHO_TIMEOUT_DEF    = us_to_cycles(32'd38_000); // 760_000
  localparam int unsigned MAX_ECHO_DEF        = us_to_cycles(32'd38_000); // 760_000
  localparam int unsigned ALARM_THRESHOLD_DEF = us_to_cycles(32'd10);     // 200
  localparam int unsigned CNT_W_DEF           = 32'd21;

endpackage

// File: rtl/parking_sensor_echo_timer.sv
// Echo input conditioning: 2-flop synchronizer, edge detector and a
// saturating pulse-width counter working on the synchronized echo.
`timescale 1ns/1ps
module echo_timer
  import parking_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned MAX_ECHO = MAX_ECHO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             echo_pulse_i,
  input  logic             arm_i,
  input  logic             count_i,
  output logic             echo_rise_o,
  output logic             echo_fall_o,
  output logic [CNT_W-1:0] width_o
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_ECHO);

  logic [1:0]       sync_q;
  logic             echo_dly_q;
  logic             echo_s;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] width_d;

  // Bring the asynchronous echo into the clock domain and keep one more delayed copy for edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= 2'b00;
      echo_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], echo_pulse_i};
      echo_dly_q <= sync_q[1];
    end
  end

  assign echo_s      = sync_q[1];
  assign echo_rise_o = echo_s & ~echo_dly_q;
  assign echo_fall_o = ~echo_s & echo_dly_q;

  // Width next-state: the rising-edge cycle is already the first high cycle, so it loads 1;
  // afterwards count every high cycle and stick at MAX_ECHO instead of wrapping.
  always_comb begin
    width_d = width_q;
    if (arm_i && echo_rise_o) begin
      width_d = ONE;
    end else if (count_i && echo_s && (width_q < MAX_W)) begin
      width_d = width_q + ONE;
    end else begin
      width_d = width_q;
    end
  end

  // Width counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q <= '0;
    end else begin
      width_q <= width_d;
    end
  end

  assign width_o = width_q;

endmodule

// File: rtl/parking_sensor_top.sv
// Parking sensor controller: periodic trigger generation, echo measurement
// sequencing and the registered proximity alarm.
`timescale 1ns/1ps
module parking_sensor_top
  import parking_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES     = TRIG_CYCLES_DEF,
  parameter int unsigned PERIOD_CYCLES   = PERIOD_CYCLES_DEF,
  parameter int unsigned ECHO_TIMEOUT    = ECHO_TIMEOUT_DEF,
  parameter int unsigned MAX_ECHO        = MAX_ECHO_DEF,
  parameter int unsigned ALARM_THRESHOLD = ALARM_THRESHOLD_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic echo_pulse,
  output logic trigger_pulse,
  output logic alarm_warning
);

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(ECHO_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] MAX_W       = CNT_W'(MAX_ECHO);
  localparam logic [CNT_W-1:0] THRESH_W    = CNT_W'(ALARM_THRESHOLD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_q, trig_d;
  logic             alarm_q, alarm_d;
  logic             period_wrap_s;
  logic             echo_rise_s;
  logic             echo_fall_s;
  logic [CNT_W-1:0] width_s;

  echo_timer #(
    .CNT_W    (CNT_W),
    .MAX_ECHO (MAX_ECHO)
  ) u_echo_timer (
    .clk          (clk),
    .reset        (reset),
    .echo_pulse_i (echo_pulse),
    .arm_i        (state_q == WAIT_ECHO),
    .count_i      (state_q == MEASURE),
    .echo_rise_o  (echo_rise_s),
    .echo_fall_o  (echo_fall_s),
    .width_o      (width_s)
  );

  assign period_wrap_s = (period_q == PERIOD_LAST);

  // Next-state logic: period counter, sequencing FSM, phase counter and alarm decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    if (period_wrap_s) begin
      period_d = '0;
    end else begin
      period_d = period_q + ONE;
    end

    case (state_q)
      IDLE: begin
        if (period_wrap_s) begin
          state_d = TRIG;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      TRIG: begin
        // Echo activity is ignored here; the edge detector is not armed.
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      WAIT_ECHO: begin
        // Only a fresh rising edge starts a measurement; a level already high is ignored.
        if (echo_rise_s) begin
          state_d = MEASURE;
        end else if (cnt_q == TMO_LAST) begin
          alarm_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      MEASURE: begin
        if (echo_fall_s) begin
          state_d = EVAL;
        end else if (width_s >= MAX_W) begin
          alarm_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = MEASURE;
        end
      end
      EVAL: begin
        alarm_d = (width_s < THRESH_W);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    trig_d = (state_d == TRIG);
  end

  // State, counters and registered outputs; the period counter is preloaded so that
  // the first trigger starts on the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      period_q <= PERIOD_LAST;
      cnt_q    <= '0;
      trig_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      alarm_q  <= alarm_d;
    end
  end

  assign trigger_pulse = trig_q;
  assign alarm_warning = alarm_q;

endmodule

// File: tb/tb_parking_sensor_top.sv
// Scoreboard bench for parking_sensor_top with shortened period/timeout values.
`timescale 1ns/1ps
module tb_parking_sensor_top;

  localparam int TRIG   = 200;
  localparam int PERIOD = 3000;
  localparam int TMO    = 1000;
  localparam int MAXE   = 1000;
  localparam int THR    = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic echo_pulse = 1'b0;
  logic trigger_pulse;
  logic alarm_warning;

  int n_checks = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  int unsigned trig_start = 0;
  bit exp_q[$];

  parking_sensor_top #(
    .TRIG_CYCLES     (TRIG),
    .PERIOD_CYCLES   (PERIOD),
    .ECHO_TIMEOUT    (TMO),
    .MAX_ECHO        (MAXE),
    .ALARM_THRESHOLD (THR),
    .CNT_W           (21)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .echo_pulse    (echo_pulse),
    .trigger_pulse (trigger_pulse),
    .alarm_warning (alarm_warning)
  );

  always #25 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_trig_rise(input string tag);
    int k = 0;
    while (trigger_pulse !== 1'b1 && k < PERIOD + 50) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (trigger_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_trig_rise: trigger_pulse=%b after %0d cycles, required 1", tag, trigger_pulse, k);
    end
    trig_start = cyc;
  endtask

  task automatic wait_trig_fall(input string tag);
    int k = 0;
    while (trigger_pulse === 1'b1 && k < TRIG + 50) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (trigger_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_trig_fall: trigger_pulse=%b after %0d cycles, required 0", tag, trigger_pulse, k);
    end
  endtask

  // Waits for the next trigger, sends one echo and queues the expected alarm.
  task automatic drive_echo(input string tag, input int delay, input int width,
                            input bit exp, output bit pre);
    wait_trig_rise(tag);
    wait_trig_fall(tag);
    repeat (delay) @(negedge clk);
    echo_pulse = 1'b1;
    repeat (width) @(negedge clk);
    pre = alarm_warning;
    echo_pulse = 1'b0;
    exp_q.push_back(exp);
  endtask

  task automatic test_reset();
    int hi = 0;
    bit al = 1'b0;
    reset = 1'b1;
    echo_pulse = 1'b0;
    #100;
    @(negedge clk);
    n_checks++;
    if (trigger_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_trigger: got %b required 0", trigger_pulse);
    end
    n_checks++;
    if (alarm_warning !== 1'b0) begin
      n_fail++; $display("FAIL reset_alarm: got %b required 0", alarm_warning);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (trigger_pulse !== 1'b1) begin
      n_fail++; $display("FAIL first_trigger_start: got %b required 1", trigger_pulse);
    end
    while (trigger_pulse === 1'b1 && hi < TRIG + 50) begin
      hi++;
      if (alarm_warning !== 1'b0) al = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (hi != TRIG) begin
      n_fail++; $display("FAIL trigger_width: got %0d cycles required %0d", hi, TRIG);
    end
    n_checks++;
    if (al !== 1'b0) begin
      n_fail++; $display("FAIL alarm_during_trigger: got %b required 0", al);
    end
  endtask

  task automatic test_close_object();
    bit pre, e;
    drive_echo("close", 10, 50, 1'b1, pre);
    n_checks++;
    if (pre !== 1'b0) begin
      n_fail++; $display("FAIL close_hold: got %b required 0", pre);
    end
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (alarm_warning !== e) begin
      n_fail++; $display("FAIL close_alarm: got %b required %b", alarm_warning, e);
    end
  endtask

  task automatic test_far_object();
    bit pre, e;
    drive_echo("far", 10, 300, 1'b0, pre);
    n_checks++;
    if (pre !== 1'b1) begin
      n_fail++; $display("FAIL far_hold: got %b required 1", pre);
    end
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (alarm_warning !== e) begin
      n_fail++; $display("FAIL far_alarm: got %b required %b", alarm_warning, e);
    end
  endtask

  task automatic test_threshold();
    bit pre, e;
    drive_echo("thr200", 10, THR, 1'b0, pre);
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (alarm_warning !== e) begin
      n_fail++; $display("FAIL threshold_equal: got %b required %b", alarm_warning, e);
    end
    drive_echo("thr198", 10, THR - 2, 1'b1, pre);
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (alarm_warning !== e) begin
      n_fail++; $display("FAIL threshold_below: got %b required %b", alarm_warning, e);
    end
  endtask

  task automatic test_timeout();
    bit e;
    int unsigned t0;
    wait_trig_rise("tmo");
    t0 = trig_start;
    wait_trig_fall("tmo");
    exp_q.push_back(1'b0);
    repeat (TMO - 1) @(negedge clk);
    n_checks++;
    if (alarm_warning !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: got %b required 1", alarm_warning);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (alarm_warning !== e) begin
      n_fail++; $display("FAIL timeout_alarm: got %b required %b", alarm_warning, e);
    end
    wait_trig_rise("tmo_next");
    n_checks++;
    if (trig_start - t0 != PERIOD) begin
      n_fail++; $display("FAIL trigger_period: got %0d cycles required %0d", trig_start - t0, PERIOD);
    end
  endtask

  task automatic test_stale_echo();
    bit e;
    wait_trig_rise("stale");
    repeat (50) @(negedge clk);
    echo_pulse = 1'b1;
    wait_trig_fall("stale");
    repeat (50) @(negedge clk);
    echo_pulse = 1'b0;
    exp_q.push_back(1'b0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (alarm_warning !== 1'b1) begin
      n_fail++; $display("FAIL stale_no_eval: got %b required 1", alarm_warning);
    end
    repeat (TMO - 54) @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (alarm_warning !== e) begin
      n_fail++; $display("FAIL stale_timeout: got %b required %b", alarm_warning, e);
    end
  endtask

  task automatic test_reset_mid_measure();
    bit e;
    int hi = 0;
    wait_trig_rise("rst");
    wait_trig_fall("rst");
    repeat (10) @(negedge clk);
    echo_pulse = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (alarm_warning !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_alarm: got %b required 1", alarm_warning);
    end
    exp_q.push_back(1'b0);
    #5;
    reset = 1'b1;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (alarm_warning !== e) begin
      n_fail++; $display("FAIL rst_async_alarm: got %b required %b", alarm_warning, e);
    end
    n_checks++;
    if (trigger_pulse !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_trigger: got %b required 0", trigger_pulse);
    end
    echo_pulse = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (trigger_pulse !== 1'b1) begin
      n_fail++; $display("FAIL rst_restart: got %b required 1", trigger_pulse);
    end
    while (trigger_pulse === 1'b1 && hi < TRIG + 50) begin
      hi++;
      @(negedge clk);
    end
    n_checks++;
    if (hi != TRIG) begin
      n_fail++; $display("FAIL rst_trigger_width: got %0d cycles required %0d", hi, TRIG);
    end
  endtask

  initial begin
    test_reset();
    test_close_object();
    test_far_object();
    test_threshold();
    test_timeout();
    test_close_object();
    test_stale_echo();
    test_close_object();
    test_reset_mid_measure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
